// File: rtl/pcileech_ft601_xfer_sched.sv
// Direction scheduler for the half-duplex FT601 bus: arbitrates RX/TX grants with burst bound,
// turnaround gap and starvation guard. Optional statistics counters: define PCILEECH_XFER_STATS_EN.
module pcileech_ft601_xfer_sched #(
    parameter int unsigned MAX_BURST    = 1024,
    parameter int unsigned TURN_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prio_rx,
    input  logic        ft601_rxf,
    input  logic        rx_ready,
    input  logic        tx_valid,
    input  logic        ft601_txe,
    input  logic        word_strobe,
    output logic        grant_rx,
    output logic        grant_tx,
    output logic        busy,
    output logic        err_strobe,
    output logic [31:0] stat_rx_words,
    output logic [31:0] stat_tx_words,
    output logic [15:0] stat_switches
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);
    localparam logic [15:0] STARVE_MAX = 16'(STARVE_LIMIT);
    localparam logic [3:0]  TURN_LAST  = 4'(TURN_CYCLES - 1);
    // With no turnaround configured a finished burst drops straight back to arbitration.
    localparam state_t      LEAVE_STATE = (TURN_CYCLES == 0) ? ST_IDLE : ST_TURN;
    localparam logic        LEAVE_BUSY  = (TURN_CYCLES == 0) ? 1'b0 : 1'b1;

    state_t      state_r;
    logic        grant_rx_r;
    logic        grant_tx_r;
    logic        busy_r;
    logic        err_r;
    logic        last_rx_r;
    logic [15:0] word_cnt_r;
    logic [3:0]  turn_cnt_r;
    logic [15:0] wait_rx_r;
    logic [15:0] wait_tx_r;

    logic rx_req_s;
    logic tx_req_s;
    logic starve_rx_s;
    logic starve_tx_s;
    logic burst_end_s;
    logic any_req_s;
    logic pick_rx_s;
    logic enter_rx_s;
    logic enter_tx_s;

    assign rx_req_s    = ft601_rxf & rx_ready;
    assign tx_req_s    = tx_valid & ft601_txe;
    assign starve_rx_s = (wait_rx_r == STARVE_MAX);
    assign starve_tx_s = (wait_tx_r == STARVE_MAX);
    assign burst_end_s = word_strobe & (word_cnt_r == BURST_LAST);
    assign enter_rx_s  = (state_r == ST_IDLE) & any_req_s & pick_rx_s;
    assign enter_tx_s  = (state_r == ST_IDLE) & any_req_s & ~pick_rx_s;

    // Arbitration: lone request, then starvation, then alternation, then priority bit.
    always_comb begin
        any_req_s = 1'b0;
        pick_rx_s = 1'b0;
        if (rx_req_s && !tx_req_s) begin
            any_req_s = 1'b1;
            pick_rx_s = 1'b1;
        end else if (!rx_req_s && tx_req_s) begin
            any_req_s = 1'b1;
            pick_rx_s = 1'b0;
        end else if (rx_req_s && tx_req_s) begin
            any_req_s = 1'b1;
            if (starve_rx_s && !starve_tx_s) begin
                pick_rx_s = 1'b1;
            end else if (!starve_rx_s && starve_tx_s) begin
                pick_rx_s = 1'b0;
            end else if (starve_rx_s && starve_tx_s) begin
                pick_rx_s = ~last_rx_r;
            end else begin
                pick_rx_s = prio_rx;
            end
        end else begin
            any_req_s = 1'b0;
            pick_rx_s = 1'b0;
        end
    end

    // Direction FSM with registered grants, busy flag, burst and turnaround counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_rx_r <= 1'b0;
            grant_tx_r <= 1'b0;
            busy_r     <= 1'b0;
            last_rx_r  <= 1'b0;
            word_cnt_r <= 16'd0;
            turn_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enter_rx_s) begin
                        state_r    <= ST_RX;
                        grant_rx_r <= 1'b1;
                        busy_r     <= 1'b1;
                        word_cnt_r <= 16'd0;
                    end else if (enter_tx_s) begin
                        state_r    <= ST_TX;
                        grant_tx_r <= 1'b1;
                        busy_r     <= 1'b1;
                        word_cnt_r <= 16'd0;
                    end
                end
                ST_RX: begin
                    if (word_strobe) begin
                        word_cnt_r <= word_cnt_r + 16'd1;
                    end
                    if (burst_end_s || !rx_req_s) begin
                        state_r    <= LEAVE_STATE;
                        grant_rx_r <= 1'b0;
                        busy_r     <= LEAVE_BUSY;
                        last_rx_r  <= 1'b1;
                        turn_cnt_r <= 4'd0;
                    end
                end
                ST_TX: begin
                    if (word_strobe) begin
                        word_cnt_r <= word_cnt_r + 16'd1;
                    end
                    if (burst_end_s || !tx_req_s) begin
                        state_r    <= LEAVE_STATE;
                        grant_tx_r <= 1'b0;
                        busy_r     <= LEAVE_BUSY;
                        last_rx_r  <= 1'b0;
                        turn_cnt_r <= 4'd0;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt_r == TURN_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        turn_cnt_r <= turn_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_rx_r <= 1'b0;
                    grant_tx_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Starvation wait counters, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_rx_r <= 16'd0;
            wait_tx_r <= 16'd0;
        end else begin
            if (!rx_req_s || enter_rx_s) begin
                wait_rx_r <= 16'd0;
            end else if (!grant_rx_r && (wait_rx_r != STARVE_MAX)) begin
                wait_rx_r <= wait_rx_r + 16'd1;
            end
            if (!tx_req_s || enter_tx_s) begin
                wait_tx_r <= 16'd0;
            end else if (!grant_tx_r && (wait_tx_r != STARVE_MAX)) begin
                wait_tx_r <= wait_tx_r + 16'd1;
            end
        end
    end

    // Sticky error: the PHY moved a word while neither direction owned the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (word_strobe && !grant_rx_r && !grant_tx_r) begin
            err_r <= 1'b1;
        end
    end

    assign grant_rx   = grant_rx_r;
    assign grant_tx   = grant_tx_r;
    assign busy       = busy_r;
    assign err_strobe = err_r;

`ifdef PCILEECH_XFER_STATS_EN
    logic [31:0] stat_rx_r;
    logic [31:0] stat_tx_r;
    logic [15:0] stat_sw_r;

    // Word and direction-switch statistics, all free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rx_r <= 32'd0;
            stat_tx_r <= 32'd0;
            stat_sw_r <= 16'd0;
        end else begin
            if (word_strobe && grant_rx_r) begin
                stat_rx_r <= stat_rx_r + 32'd1;
            end
            if (word_strobe && grant_tx_r) begin
                stat_tx_r <= stat_tx_r + 32'd1;
            end
            if ((enter_rx_s && !last_rx_r) || (enter_tx_s && last_rx_r)) begin
                stat_sw_r <= stat_sw_r + 16'd1;
            end
        end
    end

    assign stat_rx_words = stat_rx_r;
    assign stat_tx_words = stat_tx_r;
    assign stat_switches = stat_sw_r;
`else
    assign stat_rx_words = 32'd0;
    assign stat_tx_words = 32'd0;
    assign stat_switches = 16'd0;
`endif

endmodule

// File: tb/tb_pcileech_ft601_xfer_sched.sv
// Directed self-checking bench for pcileech_ft601_xfer_sched: default instance plus a
// short-burst / low-starvation-limit instance sharing the same request stimulus.
module tb_pcileech_ft601_xfer_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, prio_rx, ft601_rxf, rx_ready, tx_valid, ft601_txe, force_strobe;
    logic grant_rx_a, grant_tx_a, busy_a, err_a, strobe_a;
    logic grant_rx_b, grant_tx_b, busy_b, err_b, strobe_b;
    logic [31:0] srx_a, stx_a, srx_b, stx_b;
    logic [15:0] ssw_a, ssw_b;

    // The PHY model moves one word every granted cycle; force_strobe injects a stray word.
    assign strobe_a = force_strobe | grant_rx_a | grant_tx_a;
    assign strobe_b = force_strobe | grant_rx_b | grant_tx_b;

    pcileech_ft601_xfer_sched dut_a (
        .clk(clk), .rst(rst), .prio_rx(prio_rx), .ft601_rxf(ft601_rxf), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .ft601_txe(ft601_txe), .word_strobe(strobe_a),
        .grant_rx(grant_rx_a), .grant_tx(grant_tx_a), .busy(busy_a), .err_strobe(err_a),
        .stat_rx_words(srx_a), .stat_tx_words(stx_a), .stat_switches(ssw_a)
    );

    pcileech_ft601_xfer_sched #(.MAX_BURST(64), .TURN_CYCLES(2), .STARVE_LIMIT(10)) dut_b (
        .clk(clk), .rst(rst), .prio_rx(prio_rx), .ft601_rxf(ft601_rxf), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .ft601_txe(ft601_txe), .word_strobe(strobe_b),
        .grant_rx(grant_rx_b), .grant_tx(grant_tx_b), .busy(busy_b), .err_strobe(err_b),
        .stat_rx_words(srx_b), .stat_tx_words(stx_b), .stat_switches(ssw_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic g_rx(input bit b);
        return b ? grant_rx_b : grant_rx_a;
    endfunction

    function automatic logic g_tx(input bit b);
        return b ? grant_tx_b : grant_tx_a;
    endfunction

    // Cycles the selected grant stays high, starting from the current cycle.
    task automatic run_burst(input bit b, input bit rx, output int n);
        n = 0;
        while ((rx ? g_rx(b) : g_tx(b)) && n < 3000) begin
            n++;
            tick();
        end
    endtask

    // Cycles with both grants low, starting from the current cycle.
    task automatic run_gap(input bit b, output int n);
        n = 0;
        while (!g_rx(b) && !g_tx(b) && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n, g, hi;
        rst = 1'b1; prio_rx = 1'b0; ft601_rxf = 1'b0; rx_ready = 1'b0;
        tx_valid = 1'b0; ft601_txe = 1'b0; force_strobe = 1'b0;
        repeat (3) tick();
        chk("rst_grant_rx", grant_rx_a, 32'd0);
        chk("rst_grant_tx", grant_tx_a, 32'd0);
        chk("rst_busy", busy_a, 32'd0);
        chk("rst_err", err_a, 32'd0);
        chk("rst_stat_rx", srx_a, 32'd0);
        chk("rst_stat_sw", ssw_a, 32'd0);

        // Priority and burst bound on the default instance.
        rst = 1'b0; prio_rx = 1'b1;
        ft601_rxf = 1'b1; rx_ready = 1'b1; tx_valid = 1'b1; ft601_txe = 1'b1;
        tick();
        chk("t1_grant_rx", grant_rx_a, 32'd1);
        chk("t1_grant_tx", grant_tx_a, 32'd0);
        run_burst(1'b0, 1'b1, n);
        chk("t1_burst_len", n, 32'd1024);
        chk("t1_turn_busy", busy_a, 32'd1);
        run_gap(1'b0, g);
        chk("t1_gap", g, 32'd3);
        chk("t1_regrant_rx", grant_rx_a, 32'd1);
        chk("t1_no_err", err_a, 32'd0);

        // Starvation on the short instance: RX, then forced TX, then RX again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t2_grant_rx", grant_rx_b, 32'd1);
        run_burst(1'b1, 1'b1, n);
        chk("t2_rx_len", n, 32'd64);
        run_gap(1'b1, g);
        chk("t2_gap1", g, 32'd3);
        chk("t2_starve_tx", grant_tx_b, 32'd1);
        run_burst(1'b1, 1'b0, n);
        chk("t2_tx_len", n, 32'd64);
        run_gap(1'b1, g);
        chk("t2_gap2", g, 32'd3);
        chk("t2_rx_resume", grant_rx_b, 32'd1);

        // Early termination: RX request drops together with the 5th word.
        rst = 1'b1; tx_valid = 1'b0; ft601_rxf = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t3_grant_rx", grant_rx_a, 32'd1);
        hi = 1;
        repeat (4) begin
            tick();
            if (grant_rx_a) hi++;
        end
        ft601_rxf = 1'b0; tx_valid = 1'b1;
        tick();
        chk("t3_drop", grant_rx_a, 32'd0);
        chk("t3_words", hi, 32'd5);
`ifdef PCILEECH_XFER_STATS_EN
        chk("t3_stat_rx", srx_a, 32'd5);
        chk("t3_stat_sw", ssw_a, 32'd1);
`endif
        run_gap(1'b0, g);
        chk("t3_gap", g, 32'd3);
        chk("t3_grant_tx", grant_tx_a, 32'd1);

        // Priority flip mid-burst leaves the burst alone and steers the next arbitration.
        rst = 1'b1; ft601_rxf = 1'b1; tx_valid = 1'b1; prio_rx = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t4_grant_rx", grant_rx_a, 32'd1);
        n = 0;
        while (grant_rx_a && n < 3000) begin
            n++;
            if (n == 10) prio_rx = 1'b0;
            tick();
        end
        chk("t4_burst_len", n, 32'd1024);
        run_gap(1'b0, g);
        chk("t4_gap", g, 32'd3);
        chk("t4_pick_tx", grant_tx_a, 32'd1);
        chk("t4_not_rx", grant_rx_a, 32'd0);

        // Reset in the middle of the TX burst.
        repeat (5) tick();
        chk("t5_tx_active", grant_tx_a, 32'd1);
        chk("t5_no_err", err_a, 32'd0);
        rst = 1'b1;
        tick();
        chk("t5_rst_grant_tx", grant_tx_a, 32'd0);
        chk("t5_rst_busy", busy_a, 32'd0);
        chk("t5_rst_stat_rx", srx_a, 32'd0);
        chk("t5_rst_stat_tx", stx_a, 32'd0);
        chk("t5_rst_stat_sw", ssw_a, 32'd0);

        // Stray word during turnaround sets the sticky error.
        rst = 1'b0; tx_valid = 1'b0; ft601_rxf = 1'b1;
        tick();
        chk("t6_grant_rx", grant_rx_a, 32'd1);
        tick();
        ft601_rxf = 1'b0;
        tick();
        chk("t6_turn", grant_rx_a, 32'd0);
        chk("t6_err_clear", err_a, 32'd0);
        force_strobe = 1'b1;
        tick();
        force_strobe = 1'b0;
        chk("t6_err_set", err_a, 32'd1);
        repeat (20) tick();
        chk("t6_err_sticky", err_a, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_err_rst", err_a, 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcileech_ft601_xfer_sched.md
Name: pcileech_ft601_xfer_sched

Overview:
Direction scheduler for the half-duplex FT601 bus. It decides whether the bus serves host->FPGA reads (RX) or FPGA->host writes (TX), and for how long.
- Honours the RX/TX priority bit set by the command path.
- Bounds burst length, inserts bus turnaround gaps and prevents starvation of the non-priority direction.
- Sits between the FIFO/command network and the FT601 PHY; the PHY only moves data while the corresponding grant is high.

Parameters:
MAX_BURST, 1024, maximum 32-bit words per grant; legal range 1..65535.
TURN_CYCLES, 2, idle cycles with both grants low after each grant; legal range 0..15.
STARVE_LIMIT, 4096, cycles a pending non-granted direction may wait before it is forced next; legal range 1..65535.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
prio_rx  in  1  1 = prefer RX, 0 = prefer TX (driven by the command path)
ft601_rxf  in  1  FT601 holds host data for the FPGA
rx_ready  in  1  downstream RX path can accept data
tx_valid  in  1  TX buffer holds data
ft601_txe  in  1  FT601 can accept data
word_strobe  in  1  PHY moved one 32-bit word this cycle
grant_rx  out  1  RX direction owns the bus
grant_tx  out  1  TX direction owns the bus
busy  out  1  grant_rx | grant_tx | in TURN
err_strobe  out  1  sticky: word_strobe seen while no grant
stat_rx_words  out  32  see Optional Feature
stat_tx_words  out  32  see Optional Feature
stat_switches  out  16  see Optional Feature

Behaviour:
- Requests: rx_req = ft601_rxf & rx_ready; tx_req = tx_valid & ft601_txe.
- Reset values: state IDLE; grant_rx, grant_tx, busy, err_strobe = 0; word counter, wait counters, turn counter and stats = 0; last_dir = TX.
- States: IDLE, RX, TX, TURN. grant_rx = (state==RX) and grant_tx = (state==TX), both registered. The two grants are never high together.
- IDLE, arbitration in priority order:
  - only one request pending -> that direction;
  - both pending, exactly one direction starved -> the starved direction;
  - both pending, both starved -> opposite of last_dir;
  - otherwise prio_rx ? RX : TX;
  - no request -> remain in IDLE.
- Latency: request sampled in cycle N -> grant high in cycle N+1.
- RX/TX state:
  - word counter (16 bit) clears on entry and increments on word_strobe.
  - Leave to TURN when the strobe lands at count MAX_BURST-1, or when the own request is sampled low.
  - The grant drops in the cycle after the terminating condition. A strobe coincident with that condition is still counted.
  - last_dir updates on leaving.
- prio_rx changes during a burst take effect only at the next IDLE arbitration.
- TURN: lasts exactly TURN_CYCLES cycles, then IDLE. With TURN_CYCLES=0, go directly to IDLE.
- Minimum idle gap between grants is TURN_CYCLES+1 cycles, including the IDLE arbitration cycle.
- Starvation counters wait_rx and wait_tx (16 bit):
  - Increment each cycle the own request is high and the own grant is low.
  - Saturate at STARVE_LIMIT. starve_x = (wait_x == STARVE_LIMIT).
  - Clear when the own grant is entered, or when the own request is low.
- err_strobe: set when word_strobe is high while both grants are low, including TURN and IDLE. Cleared only by rst.
- rst mid-burst: the grant drops in the next cycle and all counters clear; there is no turnaround.

Optional Feature:
Macro: PCILEECH_XFER_STATS_EN.
- Defined:
  - stat_rx_words / stat_tx_words count word_strobe during grant_rx / grant_tx; 32 bit, wrap at 2^32.
  - stat_switches counts grant entries where the direction differs from last_dir; 16 bit, wraps.
  - All three clear on rst.
- Undefined: all three stat outputs are constant 0 and no counter logic is generated.

Test Plan:
- Setup for the tests below, unless stated otherwise: default parameters, and word_strobe driven every cycle while a grant is high.
- Priority and burst bound: both requests held high, prio_rx=1 -> grant_rx 1 cycle after request; grant_rx high for exactly 1024 strobes. Then both grants low for exactly 3 cycles. Then grant_rx again.
- Starvation (STARVE_LIMIT=10, MAX_BURST=64): prio_rx=1, both requests held high -> after the first RX burst, TX is granted once wait_tx has saturated. grant_tx is high for 64 strobes, then RX resumes.
- Early termination: RX granted, ft601_rxf drops after 5 strobes -> 5 words counted and grant_rx low on the next cycle. TX granted after the turnaround if tx_req is high.
- Priority change mid-burst: prio_rx 1->0 during an RX burst -> the RX burst completes unchanged; the next arbitration with both requests high picks TX.
- Error and reset: word_strobe during TURN -> err_strobe=1, stays set until rst. rst asserted mid-TX burst -> grant_tx=0 and all stats read 0 in the next cycle.
